ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit; the producer end of the IF→ID bus and the consumer of the dnpc returned by decode.
- Issues one instruction-memory read per instruction at the current PC and hands {pc, inst} to decode with a valid/ready handshake.
- Then waits for decode to return the next PC before fetching again.
- Non-pipelined, single outstanding request, one instruction in flight.

Parameters:
- ADDR_WIDTH, 5, register address width; carried for interface symmetry, unused internally.
- DATA_WIDTH, 32, PC and instruction width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- if_to_id_bus  out  2*DATA_WIDTH  {pc[DATA_WIDTH*2-1:DATA_WIDTH], inst[DATA_WIDTH-1:0]}, registered.
- if_to_id_valid  out  1  bus holds an unconsumed instruction.
- id_to_if_ready  in  1  decode accepts this cycle.
- id_to_if_bus  in  DATA_WIDTH  next PC (dnpc) from decode.
- id_to_if_valid  in  1  dnpc valid.
- if_to_id_ready  out  1  IFU samples dnpc this cycle.
- imem_req_valid  out  1  read request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATA_WIDTH  fetch address (= pc register).
- imem_resp_valid  in  1  read data valid.
- imem_resp_data  in  DATA_WIDTH  fetched instruction word.
- fetch_err  out  1  sticky; misaligned next PC received, fetch halted.

Behaviour:
- States:
  - FETCH: imem_req_valid=1.
  - WAIT: await response.
  - OUT: if_to_id_valid=1.
  - NPC: if_to_id_ready=1.
  - HALT.
- Reset (async, any state, any cycle):
  - state=FETCH, pc=RESET_PC.
  - if_to_id_valid=0, if_to_id_ready=0, imem_req_valid=0 while rst high, fetch_err=0, if_to_id_bus=0.
  - First request issued in the first cycle after rst deasserts.
- FETCH:
  - imem_req_addr=pc.
  - imem_req_valid && imem_req_ready → WAIT next cycle.
  - Otherwise hold request stable (addr unchanged).
  - imem_resp_valid is ignored in FETCH.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: if_to_id_bus <= {pc, imem_resp_data}, → OUT.
  - Minimum request-to-OUT latency is 2 cycles.
- OUT:
  - if_to_id_valid=1; bus held stable until handshake.
  - if_to_id_valid && id_to_if_ready → NPC next cycle, if_to_id_valid=0.
- NPC:
  - if_to_id_ready=1.
  - On id_to_if_valid, sample id_to_if_bus:
    - If [1:0]==0: pc <= dnpc, → FETCH.
    - Else: pc unchanged, fetch_err <= 1, → HALT.
  - dnpc is sampled only in NPC; id_to_if_valid in any other state is ignored.
- HALT:
  - All valid/ready outputs 0.
  - Left only by reset.
- Invariants:
  - At most one of imem_req_valid, if_to_id_valid, if_to_id_ready is high in any cycle.
  - Exactly one memory request per delivered instruction.
- Width rules: pc is DATA_WIDTH and is never incremented locally; sequential PC comes from decode.
- Memory reset: the memory shares rst, so no stale response survives reset.

Optional Feature:
- Macro: IFU_PERF_EN.
- Defined:
  - Adds output perf_fetch_cnt [31:0], incremented on each OUT handshake.
  - Adds output perf_wait_cnt [31:0], incremented every cycle spent in FETCH or WAIT.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: those ports and counters are absent; all other behaviour identical.

Test Plan:
- Reset release, memory ready=1, response 1 cycle after accept with data 32'h00000413 → imem_req_addr=32'h8000_0000 in cycle 1; if_to_id_bus={32'h8000_0000, 32'h00000413}, valid=1 in cycle 3.
- Decode ready held low 5 cycles in OUT → bus and valid stable all 5 cycles; no new imem request; accepted on cycle 6, then if_to_id_ready=1.
- In NPC, id_to_if_bus=32'h8000_0004 with valid → next cycle imem_req_addr=32'h8000_0004, imem_req_valid=1.
- imem_req_ready low 3 cycles in FETCH → request and address held; spurious imem_resp_valid during FETCH ignored; no OUT.
- dnpc=32'h8000_0006 → fetch_err=1; HALT with no further requests; asserting rst mid-HALT clears fetch_err and refetches 32'h8000_0000.
- rst asserted while in WAIT → all outputs 0 immediately (asynchronous); after release the fetch restarts at RESET_PC; with IFU_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/ifu.sv
// Non-pipelined instruction fetch unit: one imem read per instruction, hands {pc, inst} to decode
// and then waits for decode's dnpc. Optional performance counters are enabled with IFU_PERF_EN.
module ifu #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,

    output logic [2*DATA_WIDTH-1:0] if_to_id_bus,
    output logic                    if_to_id_valid,
    input  logic                    id_to_if_ready,

    input  logic [DATA_WIDTH-1:0]   id_to_if_bus,
    input  logic                    id_to_if_valid,
    output logic                    if_to_id_ready,

    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [DATA_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   imem_resp_data,

`ifdef IFU_PERF_EN
    output logic [31:0]             perf_fetch_cnt,
    output logic [31:0]             perf_wait_cnt,
`endif
    output logic                    fetch_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_NPC,
        S_HALT
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   pc;
    logic                    out_valid;
    logic                    npc_ready;
    logic                    dnpc_aligned;

    // Register widths are carried for interface symmetry only; reject nonsensical configurations.
    if (ADDR_WIDTH < 1 || DATA_WIDTH < 2) begin : g_param_check
        $error("ifu: ADDR_WIDTH must be >= 1 and DATA_WIDTH >= 2");
    end

    // The request is a decode of the FETCH state, masked while reset is held so nothing escapes
    // to memory before the first post-reset cycle.
    assign imem_req_valid = (state == S_FETCH) && !rst;
    assign imem_req_addr  = pc;
    assign if_to_id_valid = out_valid;
    assign if_to_id_ready = npc_ready;
    assign dnpc_aligned   = (id_to_if_bus[1:0] == 2'b00);

    // Main fetch sequencer; handshake outputs are set and cleared on the same edge as the state
    // change so that at most one of request/valid/ready is ever high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            if_to_id_bus <= '0;
            out_valid    <= 1'b0;
            npc_ready    <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if_to_id_bus <= {pc, imem_resp_data};
                        out_valid    <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (id_to_if_ready) begin
                        out_valid <= 1'b0;
                        npc_ready <= 1'b1;
                        state     <= S_NPC;
                    end
                end
                S_NPC: begin
                    if (id_to_if_valid) begin
                        npc_ready <= 1'b0;
                        if (dnpc_aligned) begin
                            pc    <= id_to_if_bus;
                            state <= S_FETCH;
                        end else begin
                            fetch_err <= 1'b1;
                            state     <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    out_valid <= 1'b0;
                    npc_ready <= 1'b0;
                    state     <= S_FETCH;
                end
            endcase
        end
    end

`ifdef IFU_PERF_EN
    // Delivered-instruction and memory-stall counters; both simply wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (out_valid && id_to_if_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (state == S_FETCH || state == S_WAIT) begin
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu: walks fetch, decode back-pressure, dnpc return,
// memory stalls, misaligned-PC halt and asynchronous reset in WAIT and HALT.
module tb_ifu;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*DW-1:0] if_to_id_bus;
    logic          if_to_id_valid;
    logic          id_to_if_ready;
    logic [DW-1:0] id_to_if_bus;
    logic          id_to_if_valid;
    logic          if_to_id_ready;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          fetch_err;
`ifdef IFU_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_wait_cnt;
`endif

    int checkCount = 0;
    int passCount  = 0;

    ifu #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (DW),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .if_to_id_bus    (if_to_id_bus),
        .if_to_id_valid  (if_to_id_valid),
        .id_to_if_ready  (id_to_if_ready),
        .id_to_if_bus    (id_to_if_bus),
        .id_to_if_valid  (id_to_if_valid),
        .if_to_id_ready  (if_to_id_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_wait_cnt   (perf_wait_cnt),
`endif
        .fetch_err       (fetch_err)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic reqReady, input logic respValid, input logic [DW-1:0] respData,
                                 input logic idReady, input logic idValid, input logic [DW-1:0] idBus);
        imem_req_ready  = reqReady;
        imem_resp_valid = respValid;
        imem_resp_data  = respData;
        id_to_if_ready  = idReady;
        id_to_if_valid  = idValid;
        id_to_if_bus    = idBus;
    endtask

    // Advance to just after the next rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        checkOutput({tag, "_if_valid"},  64'(if_to_id_valid), 64'd0);
        checkOutput({tag, "_if_ready"},  64'(if_to_id_ready), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (3) tick();
        checkIdle("reset");
        checkOutput("reset_err", 64'(fetch_err), 64'd0);
        checkOutput("reset_bus", if_to_id_bus, 64'd0);
`ifdef IFU_PERF_EN
        checkOutput("reset_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        checkOutput("reset_perf_wait",  64'(perf_wait_cnt),  64'd0);
`endif

        // Cycle 1: first request at RESET_PC, memory ready.
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
        checkOutput("c1_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("c1_req_addr",  64'(imem_req_addr),  64'h8000_0000);
        tick();

        // Cycle 2: WAIT, response arrives.
        checkOutput("c2_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("c2_if_valid",  64'(if_to_id_valid), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0413, 1'b0, 1'b0, '0);
        tick();

        // Cycle 3 onward: decode stalls 5 cycles; a stray dnpc in OUT must be ignored.
        checkOutput("c3_if_valid", 64'(if_to_id_valid), 64'd1);
        checkOutput("c3_bus", if_to_id_bus, {32'h8000_0000, 32'h0000_0413});
`ifdef IFU_PERF_EN
        checkOutput("c3_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        checkOutput("c3_perf_wait",  64'(perf_wait_cnt),  64'd2);
`endif
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h8000_0010);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_if_valid", 64'(if_to_id_valid), 64'd1);
            checkOutput("stall_bus", if_to_id_bus, {32'h8000_0000, 32'h0000_0413});
            checkOutput("stall_req_valid", 64'(imem_req_valid), 64'd0);
            checkOutput("stall_if_ready", 64'(if_to_id_ready), 64'd0);
            tick();
        end
        checkOutput("accept_if_valid", 64'(if_to_id_valid), 64'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        tick();

        // NPC: ready high, pc untouched by the ignored dnpc.
        checkOutput("npc_if_valid", 64'(if_to_id_valid), 64'd0);
        checkOutput("npc_if_ready", 64'(if_to_id_ready), 64'd1);
        checkOutput("npc_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("npc_pc_kept", 64'(imem_req_addr), 64'h8000_0000);
`ifdef IFU_PERF_EN
        checkOutput("npc_perf_fetch", 64'(perf_fetch_cnt), 64'd1);
`endif
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h8000_0004);
        tick();

        // FETCH at the new PC with memory stalled 3 cycles and a spurious response.
        checkOutput("f2_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("f2_req_addr",  64'(imem_req_addr),  64'h8000_0004);
        checkOutput("f2_if_ready",  64'(if_to_id_ready), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mstall_req_valid", 64'(imem_req_valid), 64'd1);
            checkOutput("mstall_req_addr",  64'(imem_req_addr),  64'h8000_0004);
            checkOutput("mstall_if_valid",  64'(if_to_id_valid), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        checkOutput("w2_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("w2_if_valid",  64'(if_to_id_valid), 64'd0);
        applyStimulus(1'b0, 1'b1, 32'h0010_0093, 1'b1, 1'b0, '0);
        tick();
        checkOutput("o2_if_valid", 64'(if_to_id_valid), 64'd1);
        checkOutput("o2_bus", if_to_id_bus, {32'h8000_0004, 32'h0010_0093});
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        checkOutput("n2_if_ready", 64'(if_to_id_ready), 64'd1);

        // Misaligned dnpc: halt with sticky error and no further requests.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h8000_0006);
        tick();
        checkOutput("halt_err", 64'(fetch_err), 64'd1);
        checkIdle("halt");
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h8000_0008);
        repeat (3) tick();
        checkIdle("halt_hold");
        checkOutput("halt_hold_err",  64'(fetch_err), 64'd1);
        checkOutput("halt_hold_addr", 64'(imem_req_addr), 64'h8000_0004);

        // Asynchronous reset from HALT, mid-cycle.
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        checkOutput("hrst_err", 64'(fetch_err), 64'd0);
        checkOutput("hrst_bus", if_to_id_bus, 64'd0);
        checkOutput("hrst_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("hrel_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("hrel_req_addr",  64'(imem_req_addr),  64'h8000_0000);

        // Reach WAIT, then reset asynchronously inside it.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("wrst_pre_req", 64'(imem_req_valid), 64'd0);
`ifdef IFU_PERF_EN
        checkOutput("wrst_pre_perf_wait", 64'(perf_wait_cnt), 64'd1);
`endif
        #3 rst = 1'b1;
        #1;
        checkIdle("wrst");
        checkOutput("wrst_err", 64'(fetch_err), 64'd0);
        checkOutput("wrst_bus", if_to_id_bus, 64'd0);
`ifdef IFU_PERF_EN
        checkOutput("wrst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        checkOutput("wrst_perf_wait",  64'(perf_wait_cnt),  64'd0);
`endif
        tick();
        rst = 1'b0;
        #1;
        checkOutput("wrel_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("wrel_req_addr",  64'(imem_req_addr),  64'h8000_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
